mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch and data-memory request ports and one shared RAM. It sits between the datapath's cache-facing interface and the RAM controller. It serializes requests with data priority and bounded instruction starvation. It returns one-cycle `ihit`/`dhit` pulses that drive the datapath's pipeline-register enables and PC enable.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while `iREN` is pending before instruction is forced next; range 1–15.
- `TIMEOUT`, 15: maximum cycles in an access state waiting for `ram_ready`; range 1–255.
- `CLK` input 1: clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `iREN` input 1: instruction read request; held by requester until `ihit`.
- `iaddr` input 32: instruction word address.
- `dREN` input 1: data read request.
- `dWEN` input 1: data write request; wins over `dREN` if both are high.
- `daddr` input 32: data address.
- `dstore` input 32: write data.
- `ihit` output 1: one-cycle pulse; `iload` is valid.
- `iload` output 32: registered instruction word.
- `dhit` output 1: one-cycle pulse; data access is done and `dload` is valid for reads.
- `dload` output 32: registered read data.
- `ramREN` output 1: RAM read strobe.
- `ramWEN` output 1: RAM write strobe.
- `ramaddr` output 32: RAM address.
- `ramstore` output 32: RAM write data.
- `ramload` input 32: RAM read data; valid when `ram_ready`=1.
- `ram_ready` input 1: RAM completes the current access this cycle.
- `err` output 1: sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, IACC, DACC, IDONE, DDONE.
- IDLE: requests are sampled only in this state.
  - If a data request (`dREN|dWEN`) is present and `starve_cnt < STARVE_MAX`, or `iREN`=0: latch `daddr`, `dstore` and `is_write = dWEN`, then go to DACC.
  - Else if `iREN`: latch `iaddr`, clear `starve_cnt`, then go to IACC.
  - Else stay in IDLE.
- `starve_cnt` (4 bits) increments on each data grant made while `iREN`=1, and saturates at `STARVE_MAX`. It clears on an instruction grant, or on a data grant with `iREN`=0.
- IACC: drive `ramREN`=1 with `ramaddr` = latched address.
  - On `ram_ready`: capture `ramload` into `iload` and go to IDONE.
- DACC: drive `ramWEN` = is_write and `ramREN` = !is_write, with latched address and data.
  - On `ram_ready`: capture `ramload` into `dload` (reads only; writes leave `dload` unchanged) and go to DDONE.
- IDONE/DDONE: assert `ihit`/`dhit` for exactly this cycle, then return to IDLE. The IDLE cycle that follows sees the requester's updated (next) request.
- Timeout: `wait_cnt` clears on entry to IACC/DACC and increments each cycle `ram_ready`=0.
  - When `wait_cnt` = TIMEOUT-1 and `ram_ready`=0: set `err`, go to IDONE/DDONE, and pulse the hit.
  - Load data on timeout is `32'hBAD1BAD1`, so the pipeline does not hang.
- Request changes during IACC/DACC are ignored; the latched access completes and the hit still pulses.
- Outputs in IDLE/DONE states: `ramREN`=`ramWEN`=0. `ramaddr`/`ramstore` hold the last latched values.

## Timing
- Reset values: state IDLE, `ihit`=`dhit`=0, `iload`=`dload`=0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, `err`=0, both counters 0.
- Reset mid-access: strobes drop asynchronously, and no hit pulses.
- `ihit`/`dhit` are registered state decodes and never glitch. They are never high together.
- Minimum latency is 3 cycles from request-sampled edge to hit (IDLE→ACC, `ram_ready` in the first ACC cycle→DONE). The hit is high in cycle 3.
- Each additional cycle of `ram_ready`=0 adds one cycle, bounded by TIMEOUT.
- RAM strobes are asserted from the first ACC cycle through the `ram_ready` cycle inclusive.
- Back-to-back throughput is one access per 3 cycles with zero-wait RAM.

## Test plan
- Reset, then `iREN`=1 with `iaddr`=0x40; RAM returns 0x8C220004 with `ram_ready` immediate → `ramREN` high 1 cycle, `ihit` pulses in cycle 3, `iload`=0x8C220004.
- `iREN` and `dREN` both high from the same IDLE cycle, `daddr`=0x100 → data is granted first (`dhit` with `dload`=RAM data), then instruction on the next IDLE; `ihit` follows 3 cycles later.
- `iREN` held high while data requests are continuous, `STARVE_MAX`=4 → exactly 4 `dhit`s, then 1 `ihit`, then data resumes.
- `dWEN`=`dREN`=1, `dstore`=0xDEADBEEF, `daddr`=0x200, RAM ready after 3 wait cycles → `ramWEN`=1 and `ramREN`=0 for 4 cycles, `dhit` once, `dload` unchanged.
- `ram_ready` held at 0, TIMEOUT=15 → after 15 ACC cycles `err`=1, the hit pulses with load 0xBAD1BAD1, and `err` stays 1 until reset.
- `nRST` asserted during DACC with `ramWEN`=1 → `ramWEN` drops immediately, no `dhit`, and the state is IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: instruction fetch and data ports share one RAM.
// Data wins in IDLE unless the instruction port has waited STARVE_MAX data grants.
// Every access takes IDLE -> ACC (>=1 cycle) -> DONE, and the hit is a state decode.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        ihit,
   output logic [31:0] iload,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic        err
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StIacc  = 3'd1;
   localparam logic [2:0] StDacc  = 3'd2;
   localparam logic [2:0] StIdone = 3'd3;
   localparam logic [2:0] StDdone = 3'd4;

   localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);
   localparam logic [7:0]  WaitLast  = 8'(TIMEOUT - 1);
   localparam logic [31:0] BadLoad   = 32'hBAD1BAD1;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] store_q, store_d;
   logic        is_write_q, is_write_d;
   logic [3:0]  starve_q, starve_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] iload_q, iload_d;
   logic [31:0] dload_q, dload_d;
   logic        err_q, err_d;

   logic data_req;
   assign data_req = dREN | dWEN;

   // Next-state: arbitration in IDLE, completion or timeout in the access states.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      store_d    = store_q;
      is_write_d = is_write_q;
      starve_d   = starve_q;
      wait_d     = wait_q;
      iload_d    = iload_q;
      dload_d    = dload_q;
      err_d      = err_q;
      case (state_q)
         StIdle: begin
            if (data_req && ((starve_q < StarveMax) || !iREN)) begin
               addr_d     = daddr;
               store_d    = dstore;
               is_write_d = dWEN;
               wait_d     = '0;
               state_d    = StDacc;
               // Only data grants that bypass a waiting fetch count toward starvation.
               if (!iREN) begin
                  starve_d = '0;
               end else if (starve_q < StarveMax) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (iREN) begin
               addr_d   = iaddr;
               starve_d = '0;
               wait_d   = '0;
               state_d  = StIacc;
            end
         end
         StIacc: begin
            if (ram_ready) begin
               iload_d = ramload;
               state_d = StIdone;
            end else if (wait_q == WaitLast) begin
               // Give up but still pulse the hit so the pipeline keeps moving.
               err_d   = 1'b1;
               iload_d = BadLoad;
               state_d = StIdone;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StDacc: begin
            if (ram_ready) begin
               if (!is_write_q) dload_d = ramload;
               state_d = StDdone;
            end else if (wait_q == WaitLast) begin
               err_d = 1'b1;
               if (!is_write_q) dload_d = BadLoad;
               state_d = StDdone;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StIdone, StDdone: state_d = StIdle;
         default:          state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         store_q    <= '0;
         is_write_q <= 1'b0;
         starve_q   <= '0;
         wait_q     <= '0;
         iload_q    <= '0;
         dload_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         is_write_q <= is_write_d;
         starve_q   <= starve_d;
         wait_q     <= wait_d;
         iload_q    <= iload_d;
         dload_q    <= dload_d;
         err_q      <= err_d;
      end
   end

   // Strobes and hits decode the registered state, so reset drops them at once.
   assign ihit     = (state_q == StIdone);
   assign dhit     = (state_q == StDdone);
   assign ramREN   = (state_q == StIacc) || ((state_q == StDacc) && !is_write_q);
   assign ramWEN   = (state_q == StDacc) && is_write_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign iload    = iload_q;
   assign dload    = dload_q;
   assign err      = err_q;

endmodule
